// File: rtl/mmio_fifo_pkg.sv
// Shared constants for the MMIO-sequenced FIFO controller: register map,
// STATUS/CTRL bit positions and controller states.
package mmio_fifo_pkg;

  localparam logic [15:0] ADDR_DATA   = 16'h0020;
  localparam logic [15:0] ADDR_STATUS = 16'h0022;
  localparam logic [15:0] ADDR_CTRL   = 16'h0024;

  localparam int STS_OVF   = 63;
  localparam int STS_UDF   = 62;
  localparam int STS_BUSY  = 18;
  localparam int STS_FULL  = 17;
  localparam int STS_EMPTY = 16;

  localparam int CTRL_FLUSH = 0;
  localparam int CTRL_CLR   = 1;

  typedef enum logic {IDLE, FLUSH} t_fifo_ctrl_state;

endpackage

// File: rtl/mmio_fifo_ctrl_if.sv
// Decoded host MMIO request strobes and the registered read response.
// Master drives requests and receives responses; slave is the controller.
interface mmio_fifo_ctrl_if;
  logic        mmio_wr_valid;
  logic [15:0] mmio_wr_addr;
  logic [63:0] mmio_wr_data;
  logic        mmio_rd_valid;
  logic [15:0] mmio_rd_addr;
  logic [8:0]  mmio_rd_tid;
  logic        rsp_valid;
  logic [8:0]  rsp_tid;
  logic [63:0] rsp_data;

  modport master (
    output mmio_wr_valid, mmio_wr_addr, mmio_wr_data,
    output mmio_rd_valid, mmio_rd_addr, mmio_rd_tid,
    input  rsp_valid, rsp_tid, rsp_data
  );

  modport slave (
    input  mmio_wr_valid, mmio_wr_addr, mmio_wr_data,
    input  mmio_rd_valid, mmio_rd_addr, mmio_rd_tid,
    output rsp_valid, rsp_tid, rsp_data
  );
endinterface

// File: rtl/fifo_occ_counter.sv
// Occupancy counter for the external FIFO; updates on the next edge, no stall.
// The caller guards inc/dec so the count stays within 0..DEPTH.
module fifo_occ_counter #(
  parameter  int DEPTH = 8,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             dec,
  input  logic             flush,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  logic take;
  assign take = dec | flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      count <= '0;
    else if (inc && !take)
      count <= count + CNT_W'(1);
    else if (!inc && take)
      count <= count - CNT_W'(1);
  end

  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/mmio_fifo_ctrl.sv
// Turns decoded MMIO DATA/STATUS/CTRL accesses into show-ahead FIFO push/pop.
// Strobes are combinational; read responses land exactly one cycle after the read.
module mmio_fifo_ctrl
  import mmio_fifo_pkg::*;
#(
  parameter  int DEPTH  = 8,
  parameter  int DATA_W = 64,
  localparam int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  mmio_fifo_ctrl_if.slave   mmio,
  output logic              fifo_push,
  output logic [DATA_W-1:0] fifo_din,
  output logic              fifo_pop,
  input  logic [DATA_W-1:0] fifo_dout,
  output logic              busy
);

  t_fifo_ctrl_state state_q, state_d;
  logic [CNT_W-1:0] count;
  logic             full, empty;
  logic             ovf_q, udf_q, ovf_evt, udf_evt;
  logic             pop_rd, pop_fl;
  logic             data_wr, data_rd, status_rd, ctrl_wr, flush_req, clr_req;
  logic [63:0]      sts, rsp_dat;

  assign data_wr   = mmio.mmio_wr_valid && (mmio.mmio_wr_addr == ADDR_DATA);
  assign ctrl_wr   = mmio.mmio_wr_valid && (mmio.mmio_wr_addr == ADDR_CTRL);
  assign data_rd   = mmio.mmio_rd_valid && (mmio.mmio_rd_addr == ADDR_DATA);
  assign status_rd = mmio.mmio_rd_valid && (mmio.mmio_rd_addr == ADDR_STATUS);
  assign flush_req = ctrl_wr && mmio.mmio_wr_data[CTRL_FLUSH];
  assign clr_req   = ctrl_wr && mmio.mmio_wr_data[CTRL_CLR];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    fifo_push = 1'b0;
    pop_rd    = 1'b0;
    pop_fl    = 1'b0;
    ovf_evt   = 1'b0;
    udf_evt   = 1'b0;
    case (state_q)
      IDLE: begin
        pop_rd    = data_rd && !empty;
        // A pop in the same cycle frees the slot, so a push at full still lands.
        fifo_push = data_wr && (!full || pop_rd);
        ovf_evt   = data_wr && !fifo_push;
        udf_evt   = data_rd && empty;
        if (flush_req && !empty && !(count == CNT_W'(1) && pop_rd))
          state_d = FLUSH;
      end
      FLUSH: begin
        pop_fl  = !empty;
        ovf_evt = data_wr;
        if (count <= CNT_W'(1))
          state_d = IDLE;
      end
    endcase
  end

  assign fifo_pop = pop_rd | pop_fl;
  assign fifo_din = fifo_push ? DATA_W'(mmio.mmio_wr_data) : '0;
  assign busy     = (state_q == FLUSH);

  fifo_occ_counter #(.DEPTH(DEPTH)) u_occ (
    .clk   (clk),
    .rst   (rst),
    .inc   (fifo_push),
    .dec   (pop_rd),
    .flush (pop_fl),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  always_comb begin
    sts            = '0;
    sts[STS_OVF]   = ovf_q;
    sts[STS_UDF]   = udf_q;
    sts[STS_BUSY]  = busy;
    sts[STS_FULL]  = full;
    sts[STS_EMPTY] = empty;
    sts[7:0]       = 8'(count);
    rsp_dat        = '0;
    if (status_rd)   rsp_dat = sts;
    else if (pop_rd) rsp_dat = 64'(fifo_dout);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_q          <= 1'b0;
      udf_q          <= 1'b0;
      mmio.rsp_valid <= 1'b0;
      mmio.rsp_tid   <= '0;
      mmio.rsp_data  <= '0;
    end else begin
      ovf_q          <= ovf_evt | (ovf_q & ~clr_req);
      udf_q          <= udf_evt | (udf_q & ~clr_req);
      mmio.rsp_valid <= data_rd | status_rd;
      mmio.rsp_tid   <= mmio.mmio_rd_tid;
      mmio.rsp_data  <= rsp_dat;
    end
  end

endmodule
